// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_pkg
// Description : Shared defaults, buffer depth and FSM state encoding for the
//               BRAM burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

   localparam int c_DATA_W_DEF = 4;
   localparam int c_ADDR_W_DEF = 3;
   localparam int c_DEPTH      = 1 << c_ADDR_W_DEF;

   // Reader FSM state encoding
   typedef logic [1:0] state_t;
   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_READ  = 2'd1;
   localparam logic [1:0] c_S_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/reader_skid.sv
`default_nettype none
// ============================================================================
// Module      : reader_skid
// Description : Two-entry output buffer with valid/ready on both sides. The
//               head entry drives the output directly from registers; the
//               tail entry absorbs the one sample still in flight when the
//               consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module reader_skid
   import bram_pkg::*;
#(
   parameter int DATA_W = c_DATA_W_DEF
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);

   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;
   logic              r_head_vld;
   logic              r_tail_vld;
   logic              w_push;
   logic              w_pop;

   // Room exists whenever the tail slot is empty
   assign in_ready  = ~r_tail_vld;
   assign w_push    = in_valid & ~r_tail_vld;
   assign w_pop     = r_head_vld & out_ready;
   assign out_valid = r_head_vld;
   assign out_data  = r_head;

   // Head/tail update: pop shifts tail into head, push fills the first free slot
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_head_vld <= 1'b0;
         r_tail_vld <= 1'b0;
      end else if (w_pop) begin
         if (r_tail_vld) begin
            r_head     <= r_tail;
            r_tail_vld <= 1'b0;
         end else if (w_push) begin
            r_head <= in_data;
         end else begin
            r_head_vld <= 1'b0;
         end
      end else if (w_push) begin
         if (!r_head_vld) begin
            r_head     <= in_data;
            r_head_vld <= 1'b1;
         end else begin
            r_tail     <= in_data;
            r_tail_vld <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_reader
// Description : Reads a burst of samples from a DPRAM starting at a tap
//               offset (wrapping naturally) and streams them out over a
//               valid/ready interface with credit-based flow control.
//               Optional macro READER_SUM_EN adds a running 'sum' output of
//               all transferred samples in the burst.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_reader
   import bram_pkg::*;
#(
   parameter int DATA_W = c_DATA_W_DEF,
   parameter int ADDR_W = c_ADDR_W_DEF
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        delay,
   input  logic [ADDR_W:0]          count,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic [DATA_W-1:0]        rd_data,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
`ifdef READER_SUM_EN
   output logic [DATA_W+ADDR_W-1:0] sum,
`endif
   output logic                     busy,
   output logic                     done
);

   localparam logic [ADDR_W:0] c_LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] c_ONE     = {{ADDR_W{1'b0}}, 1'b1};

   state_t            r_state;
   logic [ADDR_W-1:0] r_delay;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_issued;
   logic [ADDR_W:0]   r_xfers;
   logic              r_inflight;
   logic              r_busy;
   logic              r_done;

   logic [ADDR_W:0]   w_len_clamped;
   logic [ADDR_W:0]   w_issued_nxt;
   logic [ADDR_W:0]   w_xfers_nxt;
   logic              w_accept;
   logic              w_pop;
   logic              w_skid_in_ready;
   logic [2:0]        w_occ;
   logic              w_credit_ok;

   // Zero or anything beyond the buffer depth means a full-depth burst
   assign w_len_clamped = ((count == '0) || (count > c_LEN_MAX)) ? c_LEN_MAX : count;
   assign w_issued_nxt  = r_issued + c_ONE;
   assign w_xfers_nxt   = r_xfers + c_ONE;
   assign w_accept      = (r_state == c_S_IDLE) && start;
   assign w_pop         = out_valid & out_ready;

   // Occupancy = read in flight + buffered samples (head, plus tail when full).
   // A sample leaving this cycle frees its slot for a read issued this cycle.
   assign w_occ       = {2'b00, r_inflight} + {2'b00, out_valid} + {2'b00, ~w_skid_in_ready};
   assign w_credit_ok = (w_occ < (3'd2 + {2'b00, w_pop}));

   assign rd_en   = (r_state == c_S_READ) && w_credit_ok;
   assign rd_addr = r_delay + r_issued[ADDR_W-1:0];
   assign busy    = r_busy;
   assign done    = r_done;

   // Burst control: accept, issue reads under credit, drain, then pulse done
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_S_IDLE;
         r_delay    <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_xfers    <= '0;
         r_inflight <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_inflight <= rd_en;
         case (r_state)
            c_S_IDLE: begin
               if (w_accept) begin
                  r_delay  <= delay;
                  r_len    <= w_len_clamped;
                  r_issued <= '0;
                  r_xfers  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= c_S_READ;
               end
            end
            c_S_READ: begin
               if (rd_en) begin
                  r_issued <= w_issued_nxt;
                  if (w_issued_nxt == r_len) begin
                     r_state <= c_S_DRAIN;
                  end
               end
               if (w_pop) begin
                  r_xfers <= w_xfers_nxt;
               end
            end
            c_S_DRAIN: begin
               if (w_pop) begin
                  r_xfers <= w_xfers_nxt;
                  if (w_xfers_nxt == r_len) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= c_S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= c_S_IDLE;
            end
         endcase
      end
   end

   reader_skid #(
      .DATA_W(DATA_W)
   ) u_skid (
      .clock     (clock),
      .rst_n     (rst_n),
      .in_valid  (r_inflight),
      .in_data   (rd_data),
      .in_ready  (w_skid_in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

`ifdef READER_SUM_EN
   logic [DATA_W+ADDR_W-1:0] r_sum;

   // Running total of transferred samples, restarted when a burst is accepted
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= '0;
      end else if (w_accept) begin
         r_sum <= '0;
      end else if (w_pop) begin
         r_sum <= r_sum + {{ADDR_W{1'b0}}, out_data};
      end
   end

   assign sum = r_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_reader
// Description : Self-checking bench for bram_reader. A DPRAM model holds
//               1..8 at addresses 0..7; bursts are described by a table of
//               inputs and hand-computed expected addresses/samples.
//               Build with READER_SUM_EN to also check the 'sum' output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_reader;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] delay = '0;
   logic [3:0] count = '0;
   logic       rd_en;
   logic [2:0] rd_addr;
   logic [3:0] rd_data = '0;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       busy;
   logic       done;
`ifdef READER_SUM_EN
   logic [6:0] sum;
`endif

   logic [3:0] mem [8];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  delay;
      logic [3:0]  count;
      logic [3:0]  pat;      // out_ready pattern, bit k used on cycle k+1 (cyclic)
      int          n;        // expected number of samples
      logic [31:0] data;     // expected samples, nibble i = sample i
      logic [31:0] addr;     // expected read addresses, nibble i = address i
      int          sum;
      int          span;     // cycles from first to last transfer
      bit          stall;    // expect rd_en to pause mid-burst
      int          restart;  // cycle of an extra start pulse while busy (0 = none)
   } vec_t;

   vec_t vecs[7];

   bram_reader #(
      .DATA_W(4),
      .ADDR_W(3)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .start     (start),
      .delay     (delay),
      .count     (count),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef READER_SUM_EN
      .sum       (sum),
`endif
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   // DPRAM model: q is valid one cycle after the read enable
   always @(posedge clock) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_burst(input vec_t v, input bit chain);
      int  nx, ni, first_vld, first_x, last_x, done_c;
      bit  stall, prev_hold;
      logic [3:0] prev_data;
      nx = 0; ni = 0; first_vld = -1; first_x = -1; last_x = -1; done_c = -1;
      stall = 1'b0; prev_hold = 1'b0; prev_data = '0;
      for (int c = 0; c < 60 && done_c < 0; c++) begin
         if (!(chain && c == 0)) begin
            @(posedge clock);
            #1;
         end
         start = (c == 0) || (v.restart != 0 && c == v.restart);
         if (c == 0) begin
            delay = v.delay;
            count = v.count;
         end else if (c == v.restart) begin
            delay = 3'd3;
            count = 4'd2;
         end
         out_ready = (c == 0) ? 1'b1 : v.pat[(c - 1) % 4];
         #1;
         chk("credit_limit", int'(ni - nx <= 2), 1);
         if (prev_hold) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'(prev_data));
         end
         if (rd_en) begin
            if (ni < 8) chk("rd_addr", int'(rd_addr), int'(v.addr[4*ni +: 4]));
            ni++;
         end else if (ni > 0 && ni < v.n) begin
            stall = 1'b1;
         end
         if (out_valid && first_vld < 0) first_vld = c;
         if (out_valid && out_ready) begin
            if (nx < 8) chk("out_data", int'(out_data), int'(v.data[4*nx +: 4]));
            if (first_x < 0) first_x = c;
            last_x = c;
            nx++;
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
`ifdef READER_SUM_EN
         if (c == 2) chk("sum_cleared", int'(sum), 0);
`endif
         if (done && c > 0) begin
            done_c = c;
`ifdef READER_SUM_EN
            chk("sum_final", int'(sum), v.sum);
`endif
         end
      end
      start = 1'b0;
      if (done_c < 0) begin
         checks++;
         errors++;
         $display("FAIL burst_timeout: done not seen within 60 cycles (delay %0d count %0d)", v.delay, v.count);
      end
      chk("num_samples", nx, v.n);
      chk("num_reads", ni, v.n);
      chk("first_valid_cycle", first_vld, 3);
      chk("stream_span", last_x - first_x, v.span);
      chk("done_latency", done_c - last_x, 1);
      chk("rd_stall", int'(stall), int'(v.stall));
   endtask

   // After a burst (or abort) nothing may emerge until a new start
   task automatic idle_check(input int cycles);
      int bad;
      bad = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clock);
         #2;
         if (done || out_valid || busy || rd_en) bad++;
      end
      chk("idle_quiet_cycles_bad", bad, 0);
   endtask

   initial begin
      for (int a = 0; a < 8; a++) mem[a] = 4'(a + 1);
      //           delay count pat      n  data          addr          sum span stall restart
      vecs[0] = '{3'd0, 4'd8,  4'b1111, 8, 32'h87654321, 32'h76543210, 36, 7, 1'b0, 0};
      vecs[1] = '{3'd6, 4'd4,  4'b1111, 4, 32'h00002187, 32'h00001076, 18, 3, 1'b0, 0};
      vecs[2] = '{3'd6, 4'd4,  4'b1001, 4, 32'h00002187, 32'h00001076, 18, 5, 1'b1, 0};
      vecs[3] = '{3'd3, 4'd0,  4'b1111, 8, 32'h32187654, 32'h21076543, 36, 7, 1'b0, 0};
      vecs[4] = '{3'd5, 4'd12, 4'b1111, 8, 32'h54321876, 32'h43210765, 36, 7, 1'b0, 0};
      vecs[5] = '{3'd2, 4'd1,  4'b1111, 1, 32'h00000003, 32'h00000002, 3,  0, 1'b0, 0};
      vecs[6] = '{3'd0, 4'd8,  4'b1111, 8, 32'h87654321, 32'h76543210, 36, 7, 1'b0, 4};

      // Reset state
      repeat (2) @(posedge clock);
      #2;
      chk("reset_rd_en", int'(rd_en), 0);
      chk("reset_rd_addr", int'(rd_addr), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_burst(vecs[i], 1'b0);
         idle_check(5);
      end

      // New start accepted in the very cycle done pulses
      run_burst(vecs[1], 1'b0);
      run_burst(vecs[5], 1'b1);
      idle_check(5);

      // Reset asserted during the third sample transfer aborts the burst
      begin
         int nx;
         bit hit;
         nx = 0;
         hit = 1'b0;
         for (int c = 0; c < 30 && !hit; c++) begin
            @(posedge clock);
            #1;
            start = (c == 0);
            delay = 3'd0;
            count = 4'd8;
            out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) nx++;
            if (nx == 3) begin
               hit = 1'b1;
               rst_n = 1'b0;
               #1;
               chk("abort_rd_en", int'(rd_en), 0);
               chk("abort_rd_addr", int'(rd_addr), 0);
               chk("abort_out_data", int'(out_data), 0);
               chk("abort_out_valid", int'(out_valid), 0);
               chk("abort_busy", int'(busy), 0);
               chk("abort_done", int'(done), 0);
            end
         end
         start = 1'b0;
         chk("abort_reached_third_sample", int'(hit), 1);
         repeat (2) @(posedge clock);
         #1;
         rst_n = 1'b1;
         idle_check(20);
      end

      // Normal operation resumes after the abort
      run_burst(vecs[0], 1'b0);
      idle_check(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/bram_reader.md
BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 4, giving the sample width.
REQ-002 SHALL have parameter ADDR_W, default 3, giving the buffer address width (depth 2**ADDR_W = 8).
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, a single-cycle pulse that launches one read burst.
REQ-006 SHALL have port delay, input, ADDR_W bits, the first address of the burst (tap offset).
REQ-007 SHALL have port count, input, ADDR_W+1 bits, the burst length (0 and values above 8 mean 8).
REQ-008 SHALL have port rd_en, output, 1 bit, the DPRAM read enable.
REQ-009 SHALL have port rd_addr, output, ADDR_W bits, the DPRAM read address.
REQ-010 SHALL have port rd_data, input, DATA_W bits, the DPRAM q, valid one cycle after rd_en.
REQ-011 SHALL have port out_data, output, DATA_W bits, the streamed sample.
REQ-012 SHALL have port out_valid, output, 1 bit, which is high while out_data holds a sample.
REQ-013 SHALL have port out_ready, input, 1 bit, the downstream accept; a transfer occurs when out_valid and out_ready are both 1.
REQ-014 SHALL have port busy, output, 1 bit, which is high from the start capture until done.
REQ-015 SHALL have port done, output, 1 bit, a one-cycle pulse after the last transfer.

Function
REQ-016 SHALL use a finite state machine (FSM) with the states IDLE, READ and DRAIN.
REQ-017 In IDLE, start=1 SHALL latch delay and the clamped count and move the FSM to READ on the next edge.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 In READ, the block SHALL issue rd_en=1 with rd_addr = (delay + issued) mod 8, one read per cycle, whenever credit allows.
REQ-020 Credit rule: reads in flight plus buffered samples SHALL never exceed 2, so no sample is dropped under backpressure.
REQ-021 Each rd_data SHALL be captured exactly one cycle after its rd_en into the 2-entry output buffer.
REQ-022 Address wrap SHALL be natural: delay=6 with count=4 reads addresses 6, 7, 0, 1.
REQ-023 After the last read is issued, the FSM SHALL enter DRAIN; in DRAIN, rd_en SHALL be 0.
REQ-024 When the final sample transfers, done SHALL pulse on the next cycle, busy SHALL fall in that same cycle, and the FSM SHALL return to IDLE.
REQ-025 With out_ready held at 1, the first out_valid SHALL occur 3 cycles after start, and samples SHALL then stream 1 per cycle.
REQ-026 out_data and out_valid SHALL be driven from registers and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 A new start SHALL be accepted in the cycle done pulses, since the FSM is then in IDLE.

Reset
REQ-028 While rst_n=0, the FSM SHALL be in IDLE and rd_en, rd_addr, out_data, out_valid, busy and done SHALL all be 0, with counters and buffer cleared.
REQ-029 Reset asserted mid-burst SHALL abort the burst; no samples SHALL emerge and no done SHALL pulse after release.
REQ-030 Reset deassertion SHALL be recognised on the first clock edge after rst_n rises.

Configuration
REQ-031 When READER_SUM_EN is defined, the block SHALL add output sum (DATA_W+ADDR_W bits, unsigned) holding the sum of all transferred samples of the burst.
REQ-032 With READER_SUM_EN, sum SHALL be cleared on start acceptance, SHALL update on each transfer, and SHALL be final and stable when done pulses.
REQ-033 When READER_SUM_EN is not defined, the sum port and adder SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 The shared package bram_pkg SHALL hold DATA_W and ADDR_W defaults, the DEPTH constant, and the FSM state enumeration.
REQ-035 The 2-entry output buffer SHALL be the sub-module reader_skid, which has a valid/ready input side and a valid/ready output side.

Verification
REQ-036 Memory preloaded with 1..8 at addresses 0..7; start with delay=0, count=8 and out_ready=1 -> out_data 1,2,...,8 on consecutive cycles; done 1 cycle after 8; with SUM_EN, sum=36.
REQ-037 Start with delay=6, count=4 -> rd_addr 6,7,0,1 and out_data 7,8,1,2.
REQ-038 Same burst with out_ready toggling 1,0,0,1 -> no loss or duplication; rd_en stalls when credit is 2; output order is preserved.
REQ-039 count=0 -> 8 samples; count=12 -> 8 samples; a second start pulse while busy -> ignored, exactly one done.
REQ-040 rst_n pulled low on the 3rd sample -> all outputs 0 immediately; after release, out_valid=0 and done=0 until a new start.
